// File: rtl/knn_load_sequencer_if.sv
// knn_load_sequencer_if
//   Beat stream into the KNN load sequencer. One beat holds one dimension
//   for all CH channels, with channel 0 in the LSBs of s_data.
//   s_valid : producer has a beat on s_data/s_last
//   s_ready : sequencer accepts the beat this cycle
//   s_data  : CH*DATA_W payload
//   s_last  : final beat of the job
//   master  : producer side (host / testbench)
//   slave   : sequencer side
interface knn_load_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int CH     = 2
);
    logic                 s_valid;
    logic                 s_ready;
    logic [CH*DATA_W-1:0] s_data;
    logic                 s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/knn_load_sequencer.sv
// knn_load_sequencer
//   Sequences one KNN classification job into the knnTop_regwrap core.
//   The incoming beat stream is framed into one reference vector followed
//   by training vectors of DIM beats each. The sequencer drives the core's
//   reset, write strobe, data and done inputs. A truncated final training
//   vector is zero-padded. After the last write the sequencer waits DRAIN
//   cycles, then holds done/result_valid until the host acknowledges.
//
// Ports
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   start         : begin a job (honoured only in IDLE)
//   abort         : cancel the job from any non-IDLE state
//   s             : beat stream (slave modport)
//   core_reset    : one-cycle reset pulse to the core
//   core_wr_en    : core write strobe (registered)
//   core_data     : core dataValueIn (registered, holds between writes)
//   core_done     : core done (DONE state)
//   busy          : state != IDLE
//   result_valid  : core outputs are final (DONE state)
//   result_ack    : host has consumed the result
//   vec_count     : training vectors written this job, padded vector included
//   err_partial   : final training vector was zero-padded
//   err_noref     : s_last arrived during the reference vector
//
// State    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start
// LOAD_REF | accepting the DIM reference beats
// LOAD_TRN | accepting training beats, counting complete vectors
// PAD      | writing zero beats to finish a truncated training vector
// DRAIN    | waiting DRAIN cycles after the final core write
// DONE     | core_done/result_valid held until result_ack
module knn_load_sequencer #(
    parameter int DATA_W = 32,
    parameter int DIM    = 5,
    parameter int CH     = 2,
    parameter int DRAIN  = 10,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    knn_load_sequencer_if.slave  s,
    output logic                 core_reset,
    output logic                 core_wr_en,
    output logic [CH*DATA_W-1:0] core_data,
    output logic                 core_done,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ack,
    output logic [CNT_W-1:0]     vec_count,
    output logic                 err_partial,
    output logic                 err_noref
);

    localparam int BEAT_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int DRN_W  = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(DIM - 1);
    localparam logic [DRN_W-1:0]  DRAIN_LOAD = DRN_W'(DRAIN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_REF,
        ST_LOAD_TRN,
        ST_PAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [DRN_W-1:0]      drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]      vec_count_q, vec_count_d;
    logic                  err_partial_q, err_partial_d;
    logic                  err_noref_q, err_noref_d;
    logic                  core_reset_q, core_reset_d;
    logic                  wr_en_q, wr_en_d;
    logic [CH*DATA_W-1:0]  data_q, data_d;

    logic                  load_ready;
    logic                  beat_fire;
    logic                  beat_at_last;
    logic [BEAT_W-1:0]     beat_cnt_inc;
    logic [CNT_W-1:0]      vec_count_inc;

    assign load_ready    = (state_q == ST_LOAD_REF) || (state_q == ST_LOAD_TRN);
    assign s.s_ready     = load_ready;
    assign beat_fire     = s.s_valid && load_ready;
    assign beat_at_last  = (beat_cnt_q == BEAT_LAST);
    assign beat_cnt_inc  = beat_at_last ? '0 : beat_cnt_q + 1'b1;
    // vec_count sticks at all-ones rather than wrapping
    assign vec_count_inc = (vec_count_q == '1) ? vec_count_q : vec_count_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            beat_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            vec_count_q   <= '0;
            err_partial_q <= 1'b0;
            err_noref_q   <= 1'b0;
            core_reset_q  <= 1'b0;
            wr_en_q       <= 1'b0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            vec_count_q   <= vec_count_d;
            err_partial_q <= err_partial_d;
            err_noref_q   <= err_noref_d;
            core_reset_q  <= core_reset_d;
            wr_en_q       <= wr_en_d;
            data_q        <= data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        vec_count_d   = vec_count_q;
        err_partial_d = err_partial_q;
        err_noref_d   = err_noref_q;
        core_reset_d  = 1'b0;
        wr_en_d       = 1'b0;
        data_d        = data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_LOAD_REF;
                    core_reset_d  = 1'b1;
                    beat_cnt_d    = '0;
                    vec_count_d   = '0;
                    err_partial_d = 1'b0;
                    err_noref_d   = 1'b0;
                end
            end

            ST_LOAD_REF: begin
                if (beat_fire) begin
                    wr_en_d    = 1'b1;
                    data_d     = s.s_data;
                    beat_cnt_d = beat_cnt_inc;
                    if (s.s_last) begin
                        // no training data at all: the reference is not padded
                        err_noref_d = 1'b1;
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end else if (beat_at_last) begin
                        state_d = ST_LOAD_TRN;
                    end
                end
            end

            ST_LOAD_TRN: begin
                if (beat_fire) begin
                    wr_en_d    = 1'b1;
                    data_d     = s.s_data;
                    beat_cnt_d = beat_cnt_inc;
                    if (beat_at_last) begin
                        vec_count_d = vec_count_inc;
                        if (s.s_last) begin
                            state_d     = ST_DRAIN;
                            drain_cnt_d = DRAIN_LOAD;
                        end
                    end else if (s.s_last) begin
                        err_partial_d = 1'b1;
                        state_d       = ST_PAD;
                    end
                end
            end

            ST_PAD: begin
                // pad writes use the same register path as real beats
                wr_en_d    = 1'b1;
                data_d     = '0;
                beat_cnt_d = beat_cnt_inc;
                if (beat_at_last) begin
                    vec_count_d = vec_count_inc;
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end

            ST_DRAIN: begin
                // entered in the cycle the final write is presented to the core,
                // so done appears DRAIN cycles after that write
                if (drain_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end

            ST_DONE: begin
                if (result_ack) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // abort cancels everything in flight, including a beat accepted this cycle
        if (abort && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            core_reset_d  = 1'b1;
            wr_en_d       = 1'b0;
            data_d        = data_q;
            beat_cnt_d    = beat_cnt_q;
            vec_count_d   = vec_count_q;
            err_partial_d = err_partial_q;
            err_noref_d   = err_noref_q;
        end
    end

    assign core_reset   = core_reset_q;
    assign core_wr_en   = wr_en_q;
    assign core_data    = data_q;
    assign core_done    = (state_q == ST_DONE);
    assign result_valid = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign vec_count    = vec_count_q;
    assign err_partial  = err_partial_q;
    assign err_noref    = err_noref_q;

endmodule

// File: tb/tb_knn_load_sequencer.sv
module tb_knn_load_sequencer;
    localparam int DATA_W = 32;
    localparam int DIM    = 5;
    localparam int CH     = 2;
    localparam int DRAIN  = 10;
    localparam int CNT_W  = 16;
    localparam int BW     = CH * DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              result_ack = 1'b0;
    logic              core_reset, core_wr_en, core_done, busy, result_valid;
    logic              err_partial, err_noref;
    logic [BW-1:0]     core_data;
    logic [CNT_W-1:0]  vec_count;

    knn_load_sequencer_if #(.DATA_W(DATA_W), .CH(CH)) bus ();

    knn_load_sequencer #(
        .DATA_W(DATA_W), .DIM(DIM), .CH(CH), .DRAIN(DRAIN), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .s            (bus),
        .core_reset   (core_reset),
        .core_wr_en   (core_wr_en),
        .core_data    (core_data),
        .core_done    (core_done),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .vec_count    (vec_count),
        .err_partial  (err_partial),
        .err_noref    (err_noref)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard state
    logic [BW-1:0] exp_q[$];
    int  cyc = 0;
    int  last_wr_cyc = 0;
    int  wr_cnt = 0;
    int  cur_run = 0;
    int  max_run = 0;
    int  done_seen = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc++;

    // monitor: every core write must match the head of the expected queue;
    // done must rise exactly DRAIN cycles after the last write
    always @(negedge clk) begin
        if (core_wr_en) begin
            wr_cnt++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
            last_wr_cyc = cyc;
            check("write_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                check("core_data", 64'(core_data), 64'(exp_q.pop_front()));
            end
        end else begin
            cur_run = 0;
        end
        if (core_done && !done_prev) begin
            done_seen++;
            check("drain_delay", 64'(cyc - last_wr_cyc), 64'(DRAIN));
        end
        done_prev = core_done;
    end

    function automatic logic [BW-1:0] beat_data(input int i);
        logic [31:0] c0, c1;
        c0 = 32'h1000_0000 + 32'(i);
        c1 = 32'h2000_0000 + 32'(i * 3);
        return {c1, c0};
    endfunction

    // beats numbered 1..n; s_last on beat last_at (0 = none)
    task automatic send_beats(input int n, input int last_at, input bit gaps);
        for (int i = 1; i <= n; i++) begin
            bit acc;
            int waitc;
            acc = 1'b0;
            waitc = 0;
            bus.s_valid = 1'b1;
            bus.s_data  = beat_data(i);
            bus.s_last  = (i == last_at);
            while (!acc && waitc < 100) begin
                @(negedge clk);
                acc = bus.s_ready;
                @(posedge clk);
                #1;
                waitc++;
            end
            if (!acc) begin
                check("beat_accepted", 64'(acc), 64'(1));
                break;
            end
            exp_q.push_back(beat_data(i));
            if (gaps) begin
                bus.s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("core_reset_pulse", 64'(core_reset), 64'(1));
        check("busy_after_start", 64'(busy), 64'(1));
        check("vec_count_cleared", 64'(vec_count), 64'(0));
        check("errs_cleared", 64'({err_partial, err_noref}), 64'(0));
        @(posedge clk); #1;
        check("core_reset_single", 64'(core_reset), 64'(0));
        wr_cnt  = 0;
        max_run = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!core_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 64'(core_done), 64'(1));
    endtask

    task automatic ack_job();
        @(posedge clk); #1 result_ack = 1'b1;
        @(posedge clk); #1 result_ack = 1'b0;
        check("done_dropped", 64'({core_done, result_valid}), 64'(0));
        check("idle_after_ack", 64'(busy), 64'(0));
    endtask

    task automatic check_job(input int vc, input bit ep, input bit en, input int writes);
        check("vec_count", 64'(vec_count), 64'(vc));
        check("err_partial", 64'(err_partial), 64'(ep));
        check("err_noref", 64'(err_noref), 64'(en));
        check("write_count", 64'(wr_cnt), 64'(writes));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int seen;
        int held;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;

        // reset wins over start
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; start = 1'b0;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_s_ready", 64'(bus.s_ready), 64'(0));
        check("rst_outputs", 64'({core_reset, core_wr_en, core_done, result_valid}), 64'(0));
        check("rst_vec_count", 64'(vec_count), 64'(0));
        check("rst_core_data", 64'(core_data), 64'(0));

        // T1: 20 back-to-back beats, 3 training vectors
        do_start();
        send_beats(20, 20, 1'b0);
        wait_done();
        check_job(3, 1'b0, 1'b0, 20);
        check("t1_consecutive", 64'(max_run), 64'(20));
        ack_job();

        // T2: same data with gaps, writes never adjacent
        do_start();
        send_beats(20, 20, 1'b1);
        wait_done();
        check_job(3, 1'b0, 1'b0, 20);
        check("t2_gapped", 64'(max_run), 64'(1));
        ack_job();

        // T3: s_last on the 2nd beat of training vector 2 -> 3 zero pads
        do_start();
        send_beats(12, 12, 1'b0);
        repeat (3) exp_q.push_back('0);
        wait_done();
        check_job(2, 1'b1, 1'b0, 15);
        ack_job();
        check("t3_flag_holds", 64'(err_partial), 64'(1));
        check("t3_count_holds", 64'(vec_count), 64'(2));

        // T4: s_last inside the reference vector
        do_start();
        send_beats(3, 3, 1'b0);
        wait_done();
        check_job(0, 1'b0, 1'b1, 3);
        ack_job();

        // T5a: abort in LOAD_TRN while a beat is being accepted
        do_start();
        seen = done_seen;
        send_beats(8, 0, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = beat_data(9);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0; bus.s_valid = 1'b0;
        check("abort_idle", 64'(busy), 64'(0));
        check("abort_core_reset", 64'(core_reset), 64'(1));
        check("abort_wr_dropped", 64'(core_wr_en), 64'(0));
        @(posedge clk); #1;
        check("abort_reset_single", 64'(core_reset), 64'(0));

        // abort and start together in IDLE: start wins
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        check("start_beats_abort", 64'({busy, core_reset}), 64'(2'b11));
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_ref_idle", 64'(busy), 64'(0));

        // T5b: reset during DRAIN
        do_start();
        send_beats(20, 20, 1'b0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("rst_drain_idle", 64'(busy), 64'(0));
        check("rst_drain_no_pulse", 64'({core_reset, core_done}), 64'(0));
        check("rst_drain_count", 64'(vec_count), 64'(0));
        repeat (DRAIN + 10) @(posedge clk);
        #1;
        check("t5_no_done", 64'(done_seen - seen), 64'(0));
        check("t5_queue", 64'(exp_q.size()), 64'(0));

        // T6: hold off ack for 50 cycles, start ignored while busy
        do_start();
        send_beats(10, 10, 1'b0);
        wait_done();
        check_job(1, 1'b0, 1'b0, 10);
        held = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (core_done && result_valid) held++;
        end
        check("t6_held", 64'(held), 64'(50));
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("t6_start_ignored", 64'({core_reset, core_done, busy}), 64'(3'b011));
        ack_job();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
